// File: rtl/mmr_axi3_slave_if.sv
// AXI3 bundle carrying the PS7 general-purpose master port into the fabric (32-bit data).
interface axi3_if #(
  parameter int ID_W = 12
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    input  rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/mmr_axi3_slave.sv
// AXI3 register bank: RW control words out to fabric, RO status words in, with INCR/FIXED bursts.
module mmr_axi3_slave #(
  parameter int CTRL_COUNT = 8,
  parameter int STAT_COUNT = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                    fclk0,
  input  logic                    fclk0_rst_n,
  axi3_if.s                       mmr,
  output logic [CTRL_COUNT*32-1:0] ctrl,
  output logic [CTRL_COUNT-1:0]   ctrl_wr,
  input  logic [STAT_COUNT*32-1:0] stat,
  output logic [STAT_COUNT-1:0]   stat_rd
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int ID_W  = $bits(mmr.awid);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // Response encodings are ordered so the numeric maximum is the worst response.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + IDX_W'(1);
  endfunction

  logic [31:0]      ctrl_q [CTRL_COUNT];
  logic [1:0]       w_state;
  logic             aw_rdy, b_valid;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_len, w_beat;
  logic [1:0]       w_burst, w_acc, w_beat_resp;
  logic [2:0]       w_size;
  logic [ID_W-1:0]  w_id;
  logic [CTRL_COUNT-1:0] w_hot, w_apply;
  logic             w_stat_hit, w_last_beat;

  logic             unused_bits;
  assign unused_bits = ^{mmr.wid, mmr.awaddr[31:ADDR_W], mmr.awaddr[1:0],
                         mmr.araddr[31:ADDR_W], mmr.araddr[1:0]};

  for (genvar g = 0; g < CTRL_COUNT; g++) begin : g_ctrl
    assign ctrl[32*g +: 32] = ctrl_q[g];
  end

  always_comb begin
    w_hot      = '0;
    w_stat_hit = 1'b0;
    for (int k = 0; k < CTRL_COUNT; k++)
      if (w_idx == IDX_W'(k)) w_hot[k] = 1'b1;
    for (int k = 0; k < STAT_COUNT; k++)
      if (w_idx == IDX_W'(CTRL_COUNT + k)) w_stat_hit = 1'b1;
    if (!(|w_hot) && !w_stat_hit)
      w_beat_resp = RESP_DECERR;
    else if (w_stat_hit || w_size != 3'd2 || w_burst == BURST_WRAP)
      w_beat_resp = RESP_SLVERR;
    else
      w_beat_resp = RESP_OKAY;
    w_last_beat = (w_beat == w_len);
    w_apply = (w_state == W_DATA && mmr.wvalid && w_beat_resp == RESP_OKAY) ? w_hot : '0;
  end

  // Write channel: AW latch, one beat per W handshake, B after the counted last beat.
  always_ff @(posedge fclk0 or negedge fclk0_rst_n) begin
    if (!fclk0_rst_n) begin
      w_state <= W_IDLE;
      aw_rdy  <= 1'b0;
      b_valid <= 1'b0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_size  <= '0;
      w_id    <= '0;
      w_acc   <= RESP_OKAY;
      ctrl_wr <= '0;
      for (int k = 0; k < CTRL_COUNT; k++) ctrl_q[k] <= '0;
    end else begin
      ctrl_wr <= w_apply;
      for (int k = 0; k < CTRL_COUNT; k++)
        for (int b = 0; b < 4; b++)
          if (w_apply[k] && mmr.wstrb[b]) ctrl_q[k][8*b +: 8] <= mmr.wdata[8*b +: 8];
      case (w_state)
        W_IDLE: begin
          if (aw_rdy && mmr.awvalid) begin
            aw_rdy  <= 1'b0;
            w_state <= W_DATA;
            w_id    <= mmr.awid;
            w_idx   <= mmr.awaddr[ADDR_W-1:2];
            w_len   <= mmr.awlen;
            w_burst <= mmr.awburst;
            w_size  <= mmr.awsize;
            w_beat  <= '0;
            w_acc   <= RESP_OKAY;
          end else begin
            aw_rdy <= 1'b1;
          end
        end
        W_DATA: begin
          if (mmr.wvalid) begin
            // A wlast that disagrees with the beat count taints the whole burst.
            w_acc  <= resp_max(resp_max(w_acc, w_beat_resp),
                               (mmr.wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY);
            w_beat <= w_beat + 4'd1;
            w_idx  <= next_idx(w_idx, w_burst);
            if (w_last_beat) begin
              w_state <= W_RESP;
              b_valid <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (mmr.bready) begin
            b_valid <= 1'b0;
            aw_rdy  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign mmr.awready = aw_rdy;
  assign mmr.wready  = (w_state == W_DATA);
  assign mmr.bvalid  = b_valid;
  assign mmr.bid     = w_id;
  assign mmr.bresp   = w_acc;

  logic [0:0]       r_state;
  logic             ar_rdy, r_valid, r_last;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_len, r_beat;
  logic [1:0]       r_burst, r_resp;
  logic [2:0]       r_size;
  logic [ID_W-1:0]  r_id;
  logic [31:0]      r_data;
  logic [STAT_COUNT-1:0] r_stat_hot;

  logic [IDX_W-1:0] ld_idx_p0;
  logic [2:0]       ld_size_p0;
  logic [1:0]       ld_burst_p0, ld_resp_p0;
  logic [31:0]      ld_data_p0;
  logic [STAT_COUNT-1:0] ld_stat_hot_p0;
  logic             ld_ctrl_hit_p0;

  // Stage p0: decode the beat about to load, from AR in idle or the stored next address.
  always_comb begin
    ld_idx_p0      = (r_state == R_IDLE) ? mmr.araddr[ADDR_W-1:2] : r_idx;
    ld_size_p0     = (r_state == R_IDLE) ? mmr.arsize : r_size;
    ld_burst_p0    = (r_state == R_IDLE) ? mmr.arburst : r_burst;
    ld_data_p0     = '0;
    ld_ctrl_hit_p0 = 1'b0;
    ld_stat_hot_p0 = '0;
    for (int k = 0; k < CTRL_COUNT; k++)
      if (ld_idx_p0 == IDX_W'(k)) begin
        ld_ctrl_hit_p0 = 1'b1;
        ld_data_p0     = ctrl_q[k];
      end
    for (int k = 0; k < STAT_COUNT; k++)
      if (ld_idx_p0 == IDX_W'(CTRL_COUNT + k)) begin
        ld_stat_hot_p0[k] = 1'b1;
        ld_data_p0        = stat[32*k +: 32];
      end
    if (!ld_ctrl_hit_p0 && !(|ld_stat_hot_p0))
      ld_resp_p0 = RESP_DECERR;
    else if (ld_size_p0 != 3'd2 || ld_burst_p0 == BURST_WRAP)
      ld_resp_p0 = RESP_SLVERR;
    else
      ld_resp_p0 = RESP_OKAY;
    if (ld_resp_p0 != RESP_OKAY) begin
      ld_data_p0     = '0;
      ld_stat_hot_p0 = '0;
    end
  end

  // Stage p1: registered R beat, held while the master stalls.
  always_ff @(posedge fclk0 or negedge fclk0_rst_n) begin
    if (!fclk0_rst_n) begin
      r_state    <= R_IDLE;
      ar_rdy     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_burst    <= '0;
      r_size     <= '0;
      r_id       <= '0;
      r_data     <= '0;
      r_resp     <= RESP_OKAY;
      r_stat_hot <= '0;
    end else if (r_state == R_IDLE) begin
      if (ar_rdy && mmr.arvalid) begin
        ar_rdy     <= 1'b0;
        r_state    <= R_DATA;
        r_valid    <= 1'b1;
        r_id       <= mmr.arid;
        r_len      <= mmr.arlen;
        r_burst    <= mmr.arburst;
        r_size     <= mmr.arsize;
        r_beat     <= '0;
        r_last     <= (mmr.arlen == 4'd0);
        r_idx      <= next_idx(ld_idx_p0, ld_burst_p0);
        r_data     <= ld_data_p0;
        r_resp     <= ld_resp_p0;
        r_stat_hot <= ld_stat_hot_p0;
      end else begin
        ar_rdy <= 1'b1;
      end
    end else if (mmr.rready) begin
      if (r_last) begin
        r_state <= R_IDLE;
        r_valid <= 1'b0;
        ar_rdy  <= 1'b1;
      end else begin
        r_beat     <= r_beat + 4'd1;
        r_last     <= (r_beat + 4'd1 == r_len);
        r_idx      <= next_idx(r_idx, r_burst);
        r_data     <= ld_data_p0;
        r_resp     <= ld_resp_p0;
        r_stat_hot <= ld_stat_hot_p0;
      end
    end
  end

  assign mmr.arready = ar_rdy;
  assign mmr.rvalid  = r_valid;
  assign mmr.rid     = r_id;
  assign mmr.rdata   = r_data;
  assign mmr.rresp   = r_resp;
  assign mmr.rlast   = r_last;
  assign stat_rd     = (r_valid && mmr.rready) ? r_stat_hot : '0;

endmodule

// File: tb/tb_mmr_axi3_slave.sv
// Directed bench for mmr_axi3_slave: 8 control registers, 1 status word at index 8.
module tb_mmr_axi3_slave;
  localparam int ID_W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] ctrl;
  logic [7:0]   ctrl_wr;
  logic [31:0]  stat;
  logic [0:0]   stat_rd;

  int checks = 0;
  int errors = 0;

  axi3_if #(.ID_W(ID_W)) bus ();

  mmr_axi3_slave #(.CTRL_COUNT(8), .STAT_COUNT(1), .ADDR_W(12)) dut (
    .fclk0       (clk),
    .fclk0_rst_n (rst_n),
    .mmr         (bus),
    .ctrl        (ctrl),
    .ctrl_wr     (ctrl_wr),
    .stat        (stat),
    .stat_rd     (stat_rd)
  );

  always #5 clk = ~clk;

  int ctrl_wr_cnt [8];
  int ctrl_wr_total = 0;
  int stat_rd_cnt = 0;
  initial for (int k = 0; k < 8; k++) ctrl_wr_cnt[k] = 0;
  always @(negedge clk) begin
    for (int k = 0; k < 8; k++) if (ctrl_wr[k]) ctrl_wr_cnt[k]++;
    ctrl_wr_total += $countones(ctrl_wr);
    if (stat_rd[0]) stat_rd_cnt++;
  end

  logic [31:0]     rd_data [16];
  logic [1:0]      rd_resp [16];
  logic            rd_last [16];
  logic [ID_W-1:0] rd_id;
  int              rd_unstable;

  task automatic wr_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [31:0] data0,
                          input logic [3:0] strb, input int last_at,
                          output logic [1:0] resp, output logic [ID_W-1:0] bid);
    int n;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awsize = size;
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin errors++; $display("FAIL aw_timeout awready=%b want 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.wdata = data0 + 32'(i); bus.wstrb = strb; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
      n = 0;
      while (bus.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin errors++; $display("FAIL w_timeout beat=%0d wready=%b want 1", i, bus.wready); end
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin errors++; $display("FAIL b_timeout bvalid=%b want 1", bus.bvalid); end
    resp = bus.bresp; bid = bus.bid;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit stall);
    int n;
    int k;
    rd_unstable = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arsize = 3'd2;
    bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin errors++; $display("FAIL ar_timeout arready=%b want 1", bus.arready); end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (bus.rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin errors++; $display("FAIL r_timeout beat=%0d rvalid=%b want 1", i, bus.rvalid); end
      rd_data[i] = bus.rdata; rd_resp[i] = bus.rresp; rd_last[i] = bus.rlast; rd_id = bus.rid;
      if (stall) begin
        k = $urandom_range(0, 3);
        repeat (k) begin
          @(posedge clk); #1;
          if (bus.rvalid !== 1'b1 || bus.rdata !== rd_data[i] || bus.rresp !== rd_resp[i] ||
              bus.rlast !== rd_last[i]) rd_unstable++;
        end
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", bus.awready); end
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b want 0", bus.arready); end
    checks++; if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_valids got b=%b r=%b want 0 0", bus.bvalid, bus.rvalid); end
    checks++; if (ctrl !== '0 || ctrl_wr !== 8'h00 || stat_rd !== 1'b0) begin errors++; $display("FAIL rst_outputs got ctrl=%h wr=%h srd=%b want 0", ctrl, ctrl_wr, stat_rd); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_release_early awready got %b want 0", bus.awready); end
    @(posedge clk); #1;
    checks++; if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin errors++; $display("FAIL rst_ready_rise got aw=%b ar=%b want 1 1", bus.awready, bus.arready); end
  endtask

  task automatic test_single_write;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    int base = ctrl_wr_cnt[1];
    int tot = ctrl_wr_total;
    wr_burst(12'h5A3, 32'h0000_0004, 4'd0, 2'b01, 3'd2, 32'hDEADBEEF, 4'hF, 0, resp, bid);
    checks++; if (ctrl[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_ctrl1 got %h want deadbeef", ctrl[63:32]); end
    checks++; if (ctrl_wr_cnt[1] - base != 1 || ctrl_wr_total - tot != 1) begin errors++; $display("FAIL single_ctrl_wr got %0d/%0d want 1/1", ctrl_wr_cnt[1] - base, ctrl_wr_total - tot); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL single_bresp got %b want 00", resp); end
    checks++; if (bid !== 12'h5A3) begin errors++; $display("FAIL single_bid got %h want 5a3", bid); end
  endtask

  task automatic test_strobe;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    wr_burst(12'h001, 32'h0, 4'd0, 2'b01, 3'd2, 32'h11223344, 4'hF, 0, resp, bid);
    wr_burst(12'h002, 32'h0, 4'd0, 2'b01, 3'd2, 32'hAABBCCDD, 4'h5, 0, resp, bid);
    checks++; if (ctrl[31:0] !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_ctrl0 got %h want 11bb33dd", ctrl[31:0]); end
    rd_burst(12'h0C7, 32'h0, 4'd0, 2'b01, 1'b0);
    checks++; if (rd_data[0] !== 32'h11BB33DD || rd_resp[0] !== 2'b00) begin errors++; $display("FAIL strobe_read got %h/%b want 11bb33dd/00", rd_data[0], rd_resp[0]); end
    checks++; if (rd_last[0] !== 1'b1 || rd_id !== 12'h0C7) begin errors++; $display("FAIL strobe_rlast_rid got %b/%h want 1/0c7", rd_last[0], rd_id); end
  endtask

  task automatic test_incr_read;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r [4];
    int base;
    exp_d[0] = 32'h66660006; exp_d[1] = 32'h66660007; exp_d[2] = 32'hCAFE0001; exp_d[3] = 32'h0;
    exp_r[0] = 2'b00; exp_r[1] = 2'b00; exp_r[2] = 2'b00; exp_r[3] = 2'b11;
    wr_burst(12'h003, 32'h18, 4'd1, 2'b01, 3'd2, 32'h66660006, 4'hF, 1, resp, bid);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL incr_setup_bresp got %b want 00", resp); end
    for (int pass = 0; pass < 2; pass++) begin
      base = stat_rd_cnt;
      rd_burst(12'h021, 32'h18, 4'd3, 2'b01, pass == 1);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r[i] || rd_last[i] !== (i == 3)) begin
          errors++;
          $display("FAIL incr_beat pass=%0d beat=%0d got %h/%b/%b want %h/%b/%b", pass, i,
                   rd_data[i], rd_resp[i], rd_last[i], exp_d[i], exp_r[i], i == 3);
        end
      end
      checks++; if (stat_rd_cnt - base != 1) begin errors++; $display("FAIL incr_stat_rd pass=%0d got %0d want 1", pass, stat_rd_cnt - base); end
      checks++; if (rd_unstable != 0) begin errors++; $display("FAIL incr_stall_stable pass=%0d got %0d changes want 0", pass, rd_unstable); end
    end
  endtask

  task automatic test_errors;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    logic [255:0] snap;
    int tot;
    snap = ctrl; tot = ctrl_wr_total;
    wr_burst(12'h010, 32'h20, 4'd0, 2'b01, 3'd2, 32'h12345678, 4'hF, 0, resp, bid);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL stat_write_bresp got %b want 10", resp); end
    wr_burst(12'h011, 32'h0C, 4'd1, 2'b10, 3'd2, 32'h33333333, 4'hF, 1, resp, bid);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL wrap_bresp got %b want 10", resp); end
    wr_burst(12'h012, 32'h00, 4'd0, 2'b01, 3'd1, 32'h99999999, 4'hF, 0, resp, bid);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL size_bresp got %b want 10", resp); end
    checks++; if (ctrl !== snap || ctrl_wr_total != tot) begin errors++; $display("FAIL slverr_no_effect got wr=%0d ctrl_changed=%b want 0 0", ctrl_wr_total - tot, ctrl !== snap); end
    wr_burst(12'h013, 32'h40, 4'd0, 2'b01, 3'd2, 32'h44444444, 4'hF, 0, resp, bid);
    checks++; if (resp !== 2'b11) begin errors++; $display("FAIL unmapped_bresp got %b want 11", resp); end
    wr_burst(12'h014, 32'h10, 4'd2, 2'b01, 3'd2, 32'h40000000, 4'hF, 0, resp, bid);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got %b want 10", resp); end
    checks++; if (ctrl[191:160] !== 32'h40000001) begin errors++; $display("FAIL early_wlast_beat2 got %h want 40000001", ctrl[191:160]); end
    rd_burst(12'h015, 32'h40, 4'd0, 2'b01, 1'b0);
    checks++; if (rd_data[0] !== 32'h0 || rd_resp[0] !== 2'b11) begin errors++; $display("FAIL unmapped_read got %h/%b want 0/11", rd_data[0], rd_resp[0]); end
  endtask

  task automatic test_fixed;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    int base = ctrl_wr_cnt[3];
    wr_burst(12'h020, 32'h0C, 4'd2, 2'b00, 3'd2, 32'h00000030, 4'hF, 2, resp, bid);
    checks++; if (ctrl[127:96] !== 32'h00000032 || ctrl[159:128] !== 32'h40000000) begin errors++; $display("FAIL fixed_regs got %h/%h want 00000032/40000000", ctrl[127:96], ctrl[159:128]); end
    checks++; if (ctrl_wr_cnt[3] - base != 3 || resp !== 2'b00) begin errors++; $display("FAIL fixed_pulses got %0d/%b want 3/00", ctrl_wr_cnt[3] - base, resp); end
  endtask

  task automatic test_concurrent;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    int n;
    wr_burst(12'h030, 32'h08, 4'd0, 2'b01, 3'd2, 32'h22222222, 4'hF, 0, resp, bid);
    bus.awid = 12'h031; bus.awaddr = 32'h08; bus.awlen = 4'd0; bus.awburst = 2'b01; bus.awsize = 3'd2;
    bus.awvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin errors++; $display("FAIL conc_aw_timeout awready=%b want 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    checks++; if (bus.wready !== 1'b1 || bus.arready !== 1'b1) begin errors++; $display("FAIL conc_ready got w=%b ar=%b want 1 1", bus.wready, bus.arready); end
    bus.arid = 12'h032; bus.araddr = 32'h08; bus.arlen = 4'd0; bus.arburst = 2'b01; bus.arsize = 3'd2;
    bus.arvalid = 1'b1;
    bus.wdata = 32'h2BAD2BAD; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
    checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h22222222) begin errors++; $display("FAIL conc_old_value got %b/%h want 1/22222222", bus.rvalid, bus.rdata); end
    checks++; if (ctrl[95:64] !== 32'h2BAD2BAD || ctrl_wr !== 8'h04) begin errors++; $display("FAIL conc_write got %h/%h want 2bad2bad/04", ctrl[95:64], ctrl_wr); end
    checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL conc_bvalid_timing got %b want 1", bus.bvalid); end
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    rd_burst(12'h033, 32'h08, 4'd0, 2'b01, 1'b0);
    checks++; if (rd_data[0] !== 32'h2BAD2BAD) begin errors++; $display("FAIL conc_new_value got %h want 2bad2bad", rd_data[0]); end
  endtask

  task automatic test_reset_mid;
    logic [1:0] resp; logic [ID_W-1:0] bid;
    bus.arid = 12'h040; bus.araddr = 32'h0; bus.arlen = 4'd3; bus.arburst = 2'b01; bus.arsize = 3'd2;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.rready = 1'b0;
    bus.awid = 12'h041; bus.awaddr = 32'h04; bus.awlen = 4'd3; bus.awburst = 2'b01; bus.awsize = 3'd2;
    bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wdata = 32'h12340000; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
    checks++; if (bus.rvalid !== 1'b1 || ctrl[63:32] !== 32'h12340000) begin errors++; $display("FAIL mid_setup got rvalid=%b ctrl1=%h want 1/12340000", bus.rvalid, ctrl[63:32]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.rvalid !== 1'b0 || bus.bvalid !== 1'b0 || bus.wready !== 1'b0) begin errors++; $display("FAIL mid_valids got r=%b b=%b w=%b want 0 0 0", bus.rvalid, bus.bvalid, bus.wready); end
    checks++; if (ctrl !== '0 || bus.awready !== 1'b0 || bus.arready !== 1'b0) begin errors++; $display("FAIL mid_ctrl got ctrl_nz=%b aw=%b ar=%b want 0 0 0", ctrl !== '0, bus.awready, bus.arready); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    wr_burst(12'h042, 32'h14, 4'd0, 2'b01, 3'd2, 32'h55AA55AA, 4'hF, 0, resp, bid);
    checks++; if (resp !== 2'b00 || bid !== 12'h042) begin errors++; $display("FAIL post_rst_write got %b/%h want 00/042", resp, bid); end
    rd_burst(12'h043, 32'h14, 4'd0, 2'b01, 1'b0);
    checks++; if (rd_data[0] !== 32'h55AA55AA || rd_resp[0] !== 2'b00 || rd_id !== 12'h043) begin errors++; $display("FAIL post_rst_read got %h/%b/%h want 55aa55aa/00/043", rd_data[0], rd_resp[0], rd_id); end
  endtask

  initial begin
    stat = 32'hCAFE0001;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_single_write();
    test_strobe();
    test_incr_read();
    test_errors();
    test_fixed();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim time exceeded, checks=%0d", checks);
    $fatal(1);
  end
endmodule
